lcd_syscall_writer: RTL and testbench
=====================================

# lcd_syscall_writer

Downstream consumer of the datapath's LCD syscall port. Captures each `syscallW`-qualified `lcdWData` word into a small FIFO and replays it onto an HD44780-compatible 8-bit parallel LCD bus with the required setup, enable-pulse, hold and execution-wait timing. The processor never stalls on the slow display. Overflow is flagged, not back-pressured.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, at least 2.
- `T_SU`, 2: cycles with RS/DB valid before E rises.
- `T_EN`, 12: cycles E is high.
- `T_HOLD`, 2: cycles DB/RS are held after E falls.
- `T_WAIT`, 2000: post-write execution wait for normal writes.
- `T_LONG`, 82000: post-write wait for clear/home commands.
- `CLK` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low (0 = reset).
- `syscallW` in 1: write strobe from datapath, one entry per high cycle.
- `lcdWData` in 16: `[8]` = RS (1 = character data, 0 = command); `[7:0]` = byte; `[15:9]` ignored.
- `lcd_e` out 1: LCD enable.
- `lcd_rs` out 1: LCD register select.
- `lcd_rw` out 1: tied 0 (write only).
- `lcd_db` out 8: LCD data bus.
- `busy` out 1: FSM not IDLE, or FIFO non-empty.
- `full` out 1: FIFO holds DEPTH entries.
- `overflow` out 1: sticky; set when a write is dropped.

## Operation
- FIFO push: `syscallW`=1 and `full`=0 at the rising edge stores `{lcdWData[8], lcdWData[7:0]}`.
- If `syscallW`=1 while `full`=1, the word is dropped and `overflow` is set. The full check is made before any same-cycle pop, so there is no write-through when full. `overflow` clears only on reset.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. With LCD_INIT_EN, an INIT state is also present.
- IDLE: when the FIFO is non-empty, pop the head, latch RS/DB onto the outputs, load the counter with T_SU-1, and go to SETUP.
- SETUP: at count 0, go to PULSE with E=1 and the counter loaded with T_EN-1.
- PULSE: at count 0, go to HOLD with E=0 and the counter loaded with T_HOLD-1.
- HOLD: at count 0, go to WAIT.
  - Load T_LONG-1 if the entry is a long command: RS=0 and DB ∈ {0x01, 0x02, 0x03}.
  - Otherwise load T_WAIT-1.
- WAIT: at count 0, go to IDLE.
- `lcd_db`/`lcd_rs` keep their last value outside a transaction. They change only on the IDLE→SETUP edge.
- Counter width is clog2(max(T_LONG, T_WAIT)). It counts down only and never wraps.
- FIFO pointers are log2(DEPTH)+1 bits. Wrap is natural.
  - full = MSBs differ and LSBs equal.
  - empty = pointers equal.

## Timing
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_db`=0x00, `full`=0, `overflow`=0, FIFO empty, FSM IDLE. `busy`=0, or 1 with LCD_INIT_EN.
- Latency: a push at edge n gives E rising at edge n+1+T_SU. E is high for exactly T_EN cycles.
- Back-to-back entries: the next SETUP starts on the edge after WAIT expires. Per-entry period is 1+T_SU+T_EN+T_HOLD+wait.
- Simultaneous push into an empty FIFO while the FSM is in IDLE: the entry is popped on the following edge, not the same one.
- Reset asserted mid-transaction: `lcd_e` drops to 0 immediately (asynchronously), the FIFO is flushed, and the FSM goes to IDLE. The bus cycle is abandoned.

## Configuration
- `LCD_INIT_EN` defined: after reset release, INIT replays a fixed command sequence through SETUP/PULSE/HOLD/WAIT before the FIFO is serviced.
  - Sequence: 0x38, 0x0C, 0x06, 0x01, all with RS=0. 0x01 uses T_LONG.
  - During INIT, the FIFO still accepts pushes.
  - `busy`=1 from reset until the sequence completes.
- `LCD_INIT_EN` undefined: no INIT state. Software must initialise the LCD via syscalls.

## Structure
- Package `lcd_pkg`:
  - FSM state enum.
  - Default timing constants.
  - Init ROM constant, 4×9 bits.
  - `is_long_cmd(rs, db)` function.
- Sub-module `lcd_fifo`: parameterised DEPTH×9 synchronous FIFO with `full`/`empty` flags and the same CLK/Reset.
- Top: FSM, counter, output registers, overflow flag.

## Test plan
Use small timing parameters (T_SU=2, T_EN=3, T_HOLD=1, T_WAIT=4, T_LONG=10) and LCD_INIT_EN undefined unless noted.
- **Single character:** one `syscallW` with `lcdWData`=0x0141 → `lcd_rs`=1 and `lcd_db`=0x41 one edge later; `lcd_e` high for exactly 3 cycles starting 2 cycles after that; `busy` falls after 4 wait cycles.
- **Clear command:** `lcdWData`=0x0001 → `lcd_rs`=0, `lcd_db`=0x01, followed by a 10-cycle wait before the next entry starts.
- **Overflow:** 10 consecutive pushes with DEPTH=8 and the FSM stalled in WAIT → `full`=1 and `overflow`=1; exactly 8 bytes appear on the bus, in order; the dropped words never appear.
- **Reset mid-pulse:** assert `Reset`=0 while `lcd_e`=1 → `lcd_e`=0 with no clock edge; FIFO empty; `busy`=0 after release.
- **Init:** with LCD_INIT_EN defined, release reset and push 0x0148 during INIT → bus shows 0x38, 0x0C, 0x06, 0x01, then 0x48 with RS=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, default timing and init ROM for the LCD syscall writer.
// LCD_INIT_EN adds the INIT state used by the power-on command replay.
package lcd_pkg;

`ifdef LCD_INIT_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4,
        S_INIT  = 3'd5
    } lcd_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } lcd_state_t;
`endif

    localparam int LCD_DEPTH  = 8;
    localparam int LCD_T_SU   = 2;
    localparam int LCD_T_EN   = 12;
    localparam int LCD_T_HOLD = 2;
    localparam int LCD_T_WAIT = 2000;
    localparam int LCD_T_LONG = 82000;

    // Entry [0] is sent first: function set, display on, entry mode, clear.
    localparam logic [3:0][8:0] INIT_ROM = {9'h001, 9'h006, 9'h00C, 9'h038};

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
        return !rs && (db == 8'h01 || db == 8'h02 || db == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_fifo.sv
// DEPTH x 9 synchronous FIFO holding {rs, db} entries; writes when full and
// reads when empty are ignored.
module lcd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    input  logic       rd_en,
    output logic [8:0] rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr, rptr;
    logic [8:0]  mem [DEPTH];
    logic        push, pop;

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/lcd_syscall_writer.sv
// Buffers LCD syscall words and replays them as HD44780 8-bit write cycles.
// LCD_INIT_EN: replay a fixed init command sequence after reset.
//
// state | meaning
// IDLE  | waiting for a FIFO entry
// SETUP | RS/DB valid, E low, setup time
// PULSE | E high
// HOLD  | E low, RS/DB held
// WAIT  | display execution time (long for clear/home)
// INIT  | fetch next init ROM command (LCD_INIT_EN only)
module lcd_syscall_writer
    import lcd_pkg::*;
#(
    parameter int DEPTH  = LCD_DEPTH,
    parameter int T_SU   = LCD_T_SU,
    parameter int T_EN   = LCD_T_EN,
    parameter int T_HOLD = LCD_T_HOLD,
    parameter int T_WAIT = LCD_T_WAIT,
    parameter int T_LONG = LCD_T_LONG
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        syscallW,
    input  logic [15:0] lcdWData,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_db,
    output logic        busy,
    output logic        full,
    output logic        overflow
);
    localparam int CMAX = (T_LONG > T_WAIT) ? T_LONG : T_WAIT;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    lcd_state_t  state;
    logic [CW-1:0] cnt;
    logic [8:0]  head;
    logic        empty;
    logic        pop;
    logic        unused_hi;

`ifdef LCD_INIT_EN
    logic [2:0]  init_idx;
`endif

    assign unused_hi = ^lcdWData[15:9];
    assign lcd_rw    = 1'b0;
    assign pop       = (state == S_IDLE) && !empty;
    assign busy      = (state != S_IDLE) || !empty;

    lcd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .Reset   (Reset),
        .wr_en   (syscallW),
        .wr_data ({lcdWData[8], lcdWData[7:0]}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
`ifdef LCD_INIT_EN
            state    <= S_INIT;
            init_idx <= '0;
`else
            state    <= S_IDLE;
`endif
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_db   <= 8'h00;
            overflow <= 1'b0;
        end else begin
            // full here is the pre-edge value, so a same-cycle pop never frees a slot
            if (syscallW && full) overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        lcd_rs <= head[8];
                        lcd_db <= head[7:0];
                        cnt    <= CW'(T_SU - 1);
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b1;
                        cnt   <= CW'(T_EN - 1);
                        state <= S_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        cnt   <= CW'(T_HOLD - 1);
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= is_long_cmd(lcd_rs, lcd_db) ? CW'(T_LONG - 1) : CW'(T_WAIT - 1);
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
`ifdef LCD_INIT_EN
                        state <= (init_idx == 3'd4) ? S_IDLE : S_INIT;
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef LCD_INIT_EN
                S_INIT: begin
                    lcd_rs   <= INIT_ROM[init_idx[1:0]][8];
                    lcd_db   <= INIT_ROM[init_idx[1:0]][7:0];
                    init_idx <= init_idx + 1'b1;
                    cnt      <= CW'(T_SU - 1);
                    state    <= S_SETUP;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_syscall_writer.sv
// Directed bench for lcd_syscall_writer with small timing parameters.
// The init replay section runs only when LCD_INIT_EN is defined.
module tb_lcd_syscall_writer;
    localparam int DEPTH  = 8;
    localparam int T_SU   = 2;
    localparam int T_EN   = 3;
    localparam int T_HOLD = 1;
    localparam int T_WAIT = 4;
    localparam int T_LONG = 10;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        syscallW = 1'b0;
    logic [15:0] lcdWData = 16'h0000;
    logic        lcd_e, lcd_rs, lcd_rw, busy, full, overflow;
    logic [7:0]  lcd_db;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic e_q = 1'b0;
    logic [8:0] bus_q [$];
    int rise_cyc [$];
    int e_width [$];

    lcd_syscall_writer #(
        .DEPTH(DEPTH), .T_SU(T_SU), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_WAIT(T_WAIT), .T_LONG(T_LONG)
    ) dut (
        .CLK(CLK), .Reset(Reset), .syscallW(syscallW), .lcdWData(lcdWData),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db),
        .busy(busy), .full(full), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    // Bus monitor: records each write cycle seen on the LCD pins.
    always @(negedge CLK) begin
        cyc <= cyc + 1;
        e_q <= lcd_e;
        if (lcd_e && !e_q) begin
            bus_q.push_back({lcd_rs, lcd_db});
            rise_cyc.push_back(cyc);
        end
        if (!lcd_e && e_q && rise_cyc.size() > 0)
            e_width.push_back(cyc - rise_cyc[$]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_e",   {31'd0, lcd_e}, 0);
        chk("rst_rs",  {31'd0, lcd_rs}, 0);
        chk("rst_rw",  {31'd0, lcd_rw}, 0);
        chk("rst_db",  {24'd0, lcd_db}, 0);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
`ifdef LCD_INIT_EN
        chk("rst_busy", {31'd0, busy}, 1);
`else
        chk("rst_busy", {31'd0, busy}, 0);
`endif
        Reset = 1'b1;
        step();

`ifdef LCD_INIT_EN
        syscallW = 1'b1; lcdWData = 16'h0148;
        step();
        syscallW = 1'b0;
        chk("init_busy", {31'd0, busy}, 1);
        wait_idle(300);
        chk("init_count", bus_q.size(), 5);
        if (bus_q.size() == 5) begin
            chk("init_0", {23'd0, bus_q[0]}, 9'h038);
            chk("init_1", {23'd0, bus_q[1]}, 9'h00C);
            chk("init_2", {23'd0, bus_q[2]}, 9'h006);
            chk("init_3", {23'd0, bus_q[3]}, 9'h001);
            chk("init_user", {23'd0, bus_q[4]}, 9'h148);
        end
        bus_q.delete(); rise_cyc.delete(); e_width.delete();
`endif

        // single character: push at edge n
        syscallW = 1'b1; lcdWData = 16'h0141;
        step();
        syscallW = 1'b0;
        chk("c1_busy_push", {31'd0, busy}, 1);
        chk("c1_rs_before", {31'd0, lcd_rs}, 0);
        step();                                   // n+1
        chk("c1_rs", {31'd0, lcd_rs}, 1);
        chk("c1_db", {24'd0, lcd_db}, 32'h41);
        chk("c1_e_setup1", {31'd0, lcd_e}, 0);
        step();                                   // n+2
        chk("c1_e_setup2", {31'd0, lcd_e}, 0);
        step();                                   // n+3
        chk("c1_e_rise", {31'd0, lcd_e}, 1);
        step(); step();                           // n+5
        chk("c1_e_last", {31'd0, lcd_e}, 1);
        step();                                   // n+6
        chk("c1_e_fall", {31'd0, lcd_e}, 0);
        repeat (4) step();                        // n+10
        chk("c1_busy_wait", {31'd0, busy}, 1);
        step();                                   // n+11
        chk("c1_busy_done", {31'd0, busy}, 0);
        chk("c1_width", (e_width.size() > 0) ? e_width[0] : 0, 3);
        chk("c1_rw", {31'd0, lcd_rw}, 0);

        // clear command followed by a character
        bus_q.delete(); rise_cyc.delete(); e_width.delete();
        syscallW = 1'b1; lcdWData = 16'h0001;
        step();
        lcdWData = 16'h0142;
        step();
        syscallW = 1'b0;
        chk("clr_rs", {31'd0, lcd_rs}, 0);
        chk("clr_db", {24'd0, lcd_db}, 32'h01);
        wait_idle(100);
        chk("clr_count", bus_q.size(), 2);
        if (bus_q.size() == 2) begin
            chk("clr_first", {23'd0, bus_q[0]}, 9'h001);
            chk("clr_second", {23'd0, bus_q[1]}, 9'h142);
            chk("clr_period", rise_cyc[1] - rise_cyc[0], 1 + T_SU + T_EN + T_HOLD + T_LONG);
        end

        // overflow: fill while the FSM sits in the long wait of a clear
        bus_q.delete(); rise_cyc.delete(); e_width.delete();
        syscallW = 1'b1; lcdWData = 16'h0001;
        step();
        syscallW = 1'b0;
        n = 0;
        while (!lcd_e && n < 50) begin step(); n++; end
        chk("ovf_e_rise_seen", {31'd0, lcd_e}, 1);
        n = 0;
        while (lcd_e && n < 50) begin step(); n++; end
        chk("ovf_e_fall_seen", {31'd0, lcd_e}, 0);
        for (int i = 0; i < 10; i++) begin
            syscallW = 1'b1; lcdWData = 16'h0150 + 16'(i);
            step();
            if (i == 7) chk("ovf_full_at8", {31'd0, full}, 1);
            if (i == 7) chk("ovf_clear_at8", {31'd0, overflow}, 0);
        end
        syscallW = 1'b0;
        chk("ovf_full", {31'd0, full}, 1);
        chk("ovf_flag", {31'd0, overflow}, 1);
        wait_idle(300);
        chk("ovf_count", bus_q.size(), 9);
        if (bus_q.size() == 9) begin
            chk("ovf_clr", {23'd0, bus_q[0]}, 9'h001);
            for (int i = 0; i < 8; i++)
                chk($sformatf("ovf_byte%0d", i), {23'd0, bus_q[i+1]}, 32'h150 + i);
        end
        chk("ovf_full_drained", {31'd0, full}, 0);
        chk("ovf_sticky", {31'd0, overflow}, 1);

        // reset during the enable pulse
        bus_q.delete(); rise_cyc.delete(); e_width.delete();
        syscallW = 1'b1; lcdWData = 16'h0160;
        step();
        lcdWData = 16'h0161;
        step();
        syscallW = 1'b0;
        n = 0;
        while (!lcd_e && n < 50) begin step(); n++; end
        chk("mid_e_high", {31'd0, lcd_e}, 1);
        #2 Reset = 1'b0;
        #1;
        chk("mid_e_async", {31'd0, lcd_e}, 0);
        chk("mid_full", {31'd0, full}, 0);
        chk("mid_ovf", {31'd0, overflow}, 0);
`ifdef LCD_INIT_EN
        chk("mid_busy", {31'd0, busy}, 1);
`else
        chk("mid_busy", {31'd0, busy}, 0);
`endif
        @(negedge CLK);
        Reset = 1'b1;
        bus_q.delete();
`ifndef LCD_INIT_EN
        repeat (20) step();
        chk("post_busy", {31'd0, busy}, 0);
        chk("post_no_write", bus_q.size(), 0);
`else
        wait_idle(300);
        chk("post_init_count", bus_q.size(), 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
